rob_commit: RTL

- Reorder buffer at the far end of the register-file rename interface.
- Allocates rename tags at issue and receives renamed operands from the register file.
- Resolves operand tags against completed results and dispatches to the reservation stations.
- Retires results in order back to the register file; raises misprediction flush on a mispredicted head.

---
 rtl/rob_commit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer: tag allocation, operand resolution, dispatch, in-order commit (optional counters: ROB_PERF_EN)
module rob_commit #(
  parameter int ROB_ADD_W = 4,
  parameter int REG_ADD_W = 5,
  parameter int REG_DAT_W = 32,
  parameter int INS_OP_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIS_En,
  output logic [ROB_ADD_W-1:0] oRF_Qn,
  output logic                 oFull,
  input  logic                 iRF_En,
  input  logic [ROB_ADD_W-1:0] iRF_Qs1,
  input  logic [ROB_ADD_W-1:0] iRF_Qs2,
  input  logic [REG_DAT_W-1:0] iRF_Vs1,
  input  logic [REG_DAT_W-1:0] iRF_Vs2,
  input  logic [ROB_ADD_W-1:0] iRF_Qd,
  input  logic [REG_ADD_W-1:0] iRF_Rd,
  input  logic [INS_OP_W-1:0]  iRF_Op,
  input  logic [REG_DAT_W-1:0] iRF_Pc,
  input  logic [REG_DAT_W-1:0] iRF_Imm,
  input  logic                 iRF_Ils,
  output logic                 oRS_En,
  output logic [ROB_ADD_W-1:0] oRS_Qs1,
  output logic [ROB_ADD_W-1:0] oRS_Qs2,
  output logic [REG_DAT_W-1:0] oRS_Vs1,
  output logic [REG_DAT_W-1:0] oRS_Vs2,
  output logic [ROB_ADD_W-1:0] oRS_Qd,
  output logic [INS_OP_W-1:0]  oRS_Op,
  output logic [REG_DAT_W-1:0] oRS_Pc,
  output logic [REG_DAT_W-1:0] oRS_Imm,
  output logic                 oRS_Ils,
  input  logic                 iEX_En,
  input  logic [ROB_ADD_W-1:0] iEX_Q,
  input  logic [REG_DAT_W-1:0] iEX_V,
  input  logic                 iEX_Mp,
  input  logic [REG_DAT_W-1:0] iEX_Pc,
  output logic                 oRF_En,
  output logic [REG_ADD_W-1:0] oRF_Rd,
  output logic [ROB_ADD_W-1:0] oRF_Qd,
  output logic [REG_DAT_W-1:0] oRF_Vd,
  output logic                 oMp,
  output logic [REG_DAT_W-1:0] oMpPc,
  output logic [31:0]          oPerf_Commit,
  output logic [31:0]          oPerf_Mp
);
  localparam int N = 1 << ROB_ADD_W;
  localparam logic [ROB_ADD_W-1:0] TAG_ONE = ROB_ADD_W'(1);
  localparam logic [ROB_ADD_W-1:0] TAG_MAX = ROB_ADD_W'(N - 1);

  logic [ROB_ADD_W-1:0] head, tail, count;
  logic [N-1:0]         slot_valid, slot_ready, slot_mp;
  logic [REG_ADD_W-1:0] slot_rd  [N];
  logic [REG_DAT_W-1:0] slot_val [N];
  logic [REG_DAT_W-1:0] slot_pc  [N];

  logic                 blk, commit, flush, reserve, fill, wb;
  logic [ROB_ADD_W-1:0] s1_q, s2_q;
  logic [REG_DAT_W-1:0] s1_v, s2_v;

  // tag 0 means "no dependency", so the ring skips it
  function automatic logic [ROB_ADD_W-1:0] nxt(input logic [ROB_ADD_W-1:0] t);
    return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
  endfunction

  // first matching source wins: just-committed, ready slot, same-cycle result
  function automatic logic [ROB_ADD_W+REG_DAT_W-1:0] resolve(
      input logic [ROB_ADD_W-1:0] q, input logic [REG_DAT_W-1:0] v,
      input logic rdy, input logic [REG_DAT_W-1:0] sv,
      input logic lc_en, input logic [ROB_ADD_W-1:0] lc_q, input logic [REG_DAT_W-1:0] lc_v,
      input logic ex_en, input logic [ROB_ADD_W-1:0] ex_q, input logic [REG_DAT_W-1:0] ex_v);
    if (q == '0) return {q, v};
    if (lc_en && lc_q == q) return {{ROB_ADD_W{1'b0}}, lc_v};
    if (rdy) return {{ROB_ADD_W{1'b0}}, sv};
    if (ex_en && ex_q == q) return {{ROB_ADD_W{1'b0}}, ex_v};
    return {q, v};
  endfunction

  assign oRF_Qn = tail;
  assign oFull  = (count == TAG_MAX);

  // per-cycle decisions; the flush cycle blocks all incoming traffic
  always_comb begin
    blk     = oMp;
    commit  = slot_valid[head] & slot_ready[head];
    flush   = commit & slot_mp[head];
    reserve = iIS_En & ~oFull & ~blk;
    fill    = iRF_En & ~blk;
    wb      = iEX_En & ~blk & slot_valid[iEX_Q];
    {s1_q, s1_v} = resolve(iRF_Qs1, iRF_Vs1, slot_ready[iRF_Qs1], slot_val[iRF_Qs1],
                           oRF_En, oRF_Qd, oRF_Vd, iEX_En, iEX_Q, iEX_V);
    {s2_q, s2_v} = resolve(iRF_Qs2, iRF_Vs2, slot_ready[iRF_Qs2], slot_val[iRF_Qs2],
                           oRF_En, oRF_Qd, oRF_Vd, iEX_En, iEX_Q, iEX_V);
  end

  // pointers, slot status, dispatch and commit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= TAG_ONE; tail <= TAG_ONE; count <= '0;
      slot_valid <= '0; slot_ready <= '0; slot_mp <= '0;
      oRS_En <= 1'b0; oRS_Qs1 <= '0; oRS_Qs2 <= '0; oRS_Vs1 <= '0; oRS_Vs2 <= '0;
      oRS_Qd <= '0; oRS_Op <= '0; oRS_Pc <= '0; oRS_Imm <= '0; oRS_Ils <= 1'b0;
      oRF_En <= 1'b0; oRF_Rd <= '0; oRF_Qd <= '0; oRF_Vd <= '0;
      oMp <= 1'b0; oMpPc <= '0;
    end else if (en) begin
      oRS_En <= fill;
      oRF_En <= commit;
      oMp    <= flush;
      if (fill) begin
        oRS_Qs1 <= s1_q; oRS_Vs1 <= s1_v; oRS_Qs2 <= s2_q; oRS_Vs2 <= s2_v;
        oRS_Qd <= iRF_Qd; oRS_Op <= iRF_Op; oRS_Pc <= iRF_Pc;
        oRS_Imm <= iRF_Imm; oRS_Ils <= iRF_Ils;
        slot_valid[iRF_Qd] <= 1'b1; slot_ready[iRF_Qd] <= 1'b0; slot_mp[iRF_Qd] <= 1'b0;
      end
      if (wb) begin
        slot_ready[iEX_Q] <= 1'b1; slot_mp[iEX_Q] <= iEX_Mp;
      end
      if (reserve) tail <= nxt(tail);
      count <= count + ROB_ADD_W'(reserve) - ROB_ADD_W'(commit);
      if (commit) begin
        oRF_Rd <= slot_rd[head]; oRF_Qd <= head; oRF_Vd <= slot_val[head];
        head <= nxt(head);
        slot_valid[head] <= 1'b0; slot_ready[head] <= 1'b0;
      end
      if (flush) begin
        oMpPc <= slot_pc[head];
        head <= TAG_ONE; tail <= TAG_ONE; count <= '0;
        slot_valid <= '0; slot_ready <= '0;
      end
    end else begin
      oRS_En <= 1'b0; oRF_En <= 1'b0; oMp <= 1'b0;
    end
  end

  // slot payload; only meaningful while the status bits say so
  always_ff @(posedge clk) begin
    if (en) begin
      if (fill) begin
        slot_rd[iRF_Qd] <= iRF_Rd;
        slot_pc[iRF_Qd] <= '0;
      end
      if (wb) begin
        slot_val[iEX_Q] <= iEX_V;
        slot_pc[iEX_Q]  <= iEX_Pc;
      end
    end
  end

`ifdef ROB_PERF_EN
  // commit and flush counters, survive flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oPerf_Commit <= '0; oPerf_Mp <= '0;
    end else if (en) begin
      if (commit) oPerf_Commit <= oPerf_Commit + 32'd1;
      if (flush)  oPerf_Mp <= oPerf_Mp + 32'd1;
    end
  end
`else
  assign oPerf_Commit = '0;
  assign oPerf_Mp     = '0;
`endif

endmodule
